pixel_dispatcher: RTL and testbench
===================================

Name: pixel_dispatcher

Overview:
Parametrised successor to the raster coordinate distributor. It issues pixel coordinates from a programmable rectangular window, in raster order, to NUM_ENGINES engines. Each engine has its own valid/ready slot, so engines that finish early take new work immediately instead of waiting on a shared finish flag. Frame start, abort and completion are handled explicitly; the block sits between frame control and the engine array.

Parameters:
COORD_W, 16, width of every x/y coordinate
SCREEN_WIDTH, 1280, legal x range 0..SCREEN_WIDTH-1
SCREEN_HEIGHT, 720, legal y range 0..SCREEN_HEIGHT-1
NUM_ENGINES, 6, number of engine slots (1..16)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch window and begin frame
abort  in  1  synchronous; cancel frame
win_x_lo, win_x_hi  in  COORD_W each  inclusive x bounds
win_y_lo, win_y_hi  in  COORD_W each  inclusive y bounds
pix_valid  out  NUM_ENGINES  slot i holds an unconsumed pixel
pix_x, pix_y  out  [NUM_ENGINES] x COORD_W  coordinates per slot
pix_ready  in  NUM_ENGINES  engine i accepts its slot this cycle
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse at frame completion
cfg_err  out  1  one-cycle pulse when start carries a bad window
stall_cycles  out  32  optional counter (see below)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all pix_valid=0, pix_x/pix_y=0, busy=0, frame_done=0, cfg_err=0, stall_cycles=0.
- States: IDLE, RUN, DRAIN.
- IDLE + start:
  - If the window is valid (x_lo<=x_hi<SCREEN_WIDTH and y_lo<=y_hi<SCREEN_HEIGHT) and x_hi-x_lo+1 >= NUM_ENGINES: latch the window, set cursor=(x_lo,y_lo), go to RUN.
  - Otherwise: pulse cfg_err the next cycle and stay in IDLE.
- start outside IDLE is ignored.
- Slot i is free in a cycle if !pix_valid[i] or (pix_valid[i] && pix_ready[i]). The transfer is pix_valid & pix_ready, sampled at the clock edge.
- RUN allocation, each cycle:
  - Free slots are filled in ascending index order with consecutive x values (cursor.x, cursor.x+1, ...) on row cursor.y.
  - Allocation stops at win_x_hi; no row wrap within a cycle.
  - Loaded slots show the new pixel_valid=1 on the next cycle.
  - Cursor advances by the number issued. If the row ends, cursor becomes (x_lo, y+1).
  - Non-free slots hold their values stable (AXI-style; no change while valid && !ready).
- Issue width per cycle is at most min(free slots, pixels left in row). Per-slot adders only; no divide or modulo.
- After (x_hi,y_hi) is issued: go to DRAIN.
- DRAIN: wait until all pix_valid=0. Then pulse frame_done for one cycle (the cycle the state returns to IDLE); busy drops in the same cycle.
- abort (RUN or DRAIN): next cycle all pix_valid=0, state IDLE, no frame_done. In IDLE, abort is a no-op. abort wins over a simultaneous start.
- reset_n deasserted mid-frame: outputs return to reset values asynchronously; no frame_done.
- Single-pixel frame (x_lo=x_hi, y_lo=y_hi) is illegal when NUM_ENGINES>1 (width rule) and gives cfg_err. With NUM_ENGINES=1 it issues one pixel and then frame_done.
- Coordinate arithmetic is in COORD_W+1 bits so x_hi=2^COORD_W-1 cannot wrap.

Optional Feature:
- Macro PIXEL_DISPATCHER_STALL_CNT_EN.
- Defined: stall_cycles counts RUN cycles where at least one slot has pix_valid=1 and pix_ready=0, and no slot is free.
  - Cleared on start-accept and on reset; saturates at 2^32-1.
  - Holds its value in IDLE.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Package pixel_dispatch_pkg: typedef coord_t (COORD_W bits), struct window_t {x_lo, x_hi, y_lo, y_hi}, enum dispatch_state_e {IDLE, RUN, DRAIN}.
- Sub-module pixel_slot_alloc: combinational prefix count of free slots clipped to the pixels remaining in the row. It outputs per-slot load enables, per-slot x offsets, and the issue count.

Test Plan:
- Window (0..7, 0..1), N=6, all ready=1: cycle 1 slots 0-5 get x=0..5 y=0; cycle 2 slots 0-1 get x=6,7 y=0; cycle 3 x=0..5 y=1; cycle 4 x=6,7 y=1. frame_done pulses once after drain; 16 unique pixels total.
- Same window, ready[3]=0 held for 10 cycles: slot 3 holds (3,0) stable with valid=1; other slots keep receiving pixels; no pixel lost or duplicated. With the macro enabled, stall_cycles>0 only once all slots are blocked.
- start with win_x_hi=1280: cfg_err pulses, busy stays 0, no pix_valid. start with width 4 < N=6: cfg_err.
- abort asserted mid-frame after 10 pixels: next cycle pix_valid=0, busy=0, no frame_done. A new start restarts at (x_lo,y_lo).
- reset_n pulled low while pix_valid=6'h3F: outputs clear immediately without waiting for a clock edge. After release, state is IDLE and stall_cycles=0.
- start asserted during RUN with a different window: ignored; the original window completes with exactly (x_hi-x_lo+1)*(y_hi-y_lo+1) transfers.

Source files
------------

// File: rtl/pixel_dispatcher_pkg.sv
// Shared types for the pixel dispatcher: coordinate/window records, FSM states
// and a counter-width helper.
package pixel_dispatch_pkg;

  localparam int COORD_W_DEF = 16;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t x_lo;
    coord_t x_hi;
    coord_t y_lo;
    coord_t y_hi;
  } window_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dispatch_state_e;

  // Bits needed to hold a count of 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Per-engine valid/ready slot bundle between the dispatcher (master) and the
// engine array (slave).
interface pixel_dispatcher_if #(
  parameter int NUM_ENGINES = 6,
  parameter int COORD_W     = 16
);
  logic [NUM_ENGINES-1:0]              pix_valid;
  logic [NUM_ENGINES-1:0][COORD_W-1:0] pix_x;
  logic [NUM_ENGINES-1:0][COORD_W-1:0] pix_y;
  logic [NUM_ENGINES-1:0]              pix_ready;

  modport master (output pix_valid, pix_x, pix_y, input  pix_ready);
  modport slave  (input  pix_valid, pix_x, pix_y, output pix_ready);
endinterface

// File: rtl/pixel_dispatcher_slot_alloc.sv
// Prefix count over free slots, clipped to the pixels left in the current row:
// yields per-slot load enables, per-slot x offsets and the issue count.
module pixel_slot_alloc
  import pixel_dispatch_pkg::*;
#(
  parameter  int NUM_ENGINES = 6,
  parameter  int COORD_W     = 16,
  localparam int CNT_W       = cnt_width(NUM_ENGINES)
) (
  input  logic [NUM_ENGINES-1:0]            free_i,
  input  logic [COORD_W:0]                  row_left_i,
  output logic [NUM_ENGINES-1:0]            load_o,
  output logic [NUM_ENGINES-1:0][CNT_W-1:0] x_off_o,
  output logic [CNT_W-1:0]                  issue_cnt_o
);

  always_comb begin
    logic [CNT_W-1:0] rank;
    rank    = '0;
    load_o  = '0;
    x_off_o = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      x_off_o[i] = rank;
      if (free_i[i] && ((COORD_W+1)'(rank) < row_left_i)) begin
        load_o[i] = 1'b1;
        rank      = rank + 1'b1;
      end
    end
    issue_cnt_o = rank;
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order pixel issue from a latched window to NUM_ENGINES valid/ready slots.
// Optional stall counter built only when PIXEL_DISPATCHER_STALL_CNT_EN is defined.
//   state | meaning
//   IDLE  | waiting for start; window check on start
//   RUN   | filling free slots from the cursor
//   DRAIN | last pixel issued, waiting for all slots to empty
module pixel_dispatcher
  import pixel_dispatch_pkg::*;
#(
  parameter int COORD_W       = COORD_W_DEF,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int NUM_ENGINES   = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [COORD_W-1:0]  win_x_lo,
  input  logic [COORD_W-1:0]  win_x_hi,
  input  logic [COORD_W-1:0]  win_y_lo,
  input  logic [COORD_W-1:0]  win_y_hi,
  pixel_dispatcher_if.master  pix_if,
  output logic                busy,
  output logic                frame_done,
  output logic                cfg_err,
  output logic [31:0]         stall_cycles
);

  localparam int CNT_W = cnt_width(NUM_ENGINES);
  typedef logic [COORD_W:0] wide_t;

  dispatch_state_e                     state_q;
  logic [COORD_W-1:0]                  x_lo_q, x_hi_q, y_hi_q;
  logic [COORD_W-1:0]                  cur_x_q, cur_y_q;
  logic [NUM_ENGINES-1:0]              valid_q;
  logic [NUM_ENGINES-1:0][COORD_W-1:0] px_q, py_q;
  logic                                busy_q, done_q, err_q;

  logic                                win_ok, start_acc, row_end;
  logic [NUM_ENGINES-1:0]              free, load;
  logic [NUM_ENGINES-1:0][CNT_W-1:0]   x_off;
  logic [CNT_W-1:0]                    issue_cnt;
  wide_t                               row_left;

  // All window arithmetic is one bit wider so x_hi at the top of the range cannot wrap.
  always_comb begin
    win_ok = (win_x_lo <= win_x_hi) && (win_y_lo <= win_y_hi)
          && (wide_t'(win_x_hi) < wide_t'(SCREEN_WIDTH))
          && (wide_t'(win_y_hi) < wide_t'(SCREEN_HEIGHT))
          && ((wide_t'(win_x_hi) - wide_t'(win_x_lo) + wide_t'(1)) >= wide_t'(NUM_ENGINES));
  end

  assign start_acc = (state_q == IDLE) && start && !abort && win_ok;
  assign free      = ~valid_q | pix_if.pix_ready;
  assign row_left  = wide_t'(x_hi_q) - wide_t'(cur_x_q) + wide_t'(1);
  assign row_end   = (wide_t'(issue_cnt) == row_left);

  pixel_slot_alloc #(
    .NUM_ENGINES (NUM_ENGINES),
    .COORD_W     (COORD_W)
  ) u_alloc (
    .free_i      (free),
    .row_left_i  (row_left),
    .load_o      (load),
    .x_off_o     (x_off),
    .issue_cnt_o (issue_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_lo_q  <= '0;
      x_hi_q  <= '0;
      y_hi_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      valid_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            x_lo_q  <= win_x_lo;
            x_hi_q  <= win_x_hi;
            y_hi_q  <= win_y_hi;
            cur_x_q <= win_x_lo;
            cur_y_q <= win_y_lo;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else if (start && !abort) begin
            err_q <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            valid_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
              if (load[i]) begin
                valid_q[i] <= 1'b1;
                px_q[i]    <= cur_x_q + COORD_W'(x_off[i]);
                py_q[i]    <= cur_y_q;
              end else if (pix_if.pix_ready[i]) begin
                valid_q[i] <= 1'b0;
              end
            end
            if (row_end) begin
              if (cur_y_q == y_hi_q) begin
                state_q <= DRAIN;
              end else begin
                cur_x_q <= x_lo_q;
                cur_y_q <= cur_y_q + 1'b1;
              end
            end else begin
              cur_x_q <= cur_x_q + COORD_W'(issue_cnt);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            valid_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (valid_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            valid_q <= valid_q & ~pix_if.pix_ready;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_DISPATCHER_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        all_blocked;

  assign all_blocked = (free == '0) && |(valid_q & ~pix_if.pix_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && all_blocked && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign pix_if.pix_valid = valid_q;
  assign pix_if.pix_x     = px_q;
  assign pix_if.pix_y     = py_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher: table-driven frames, hand-written
// corner sequences and randomized ready/window stimulus against a slot-level model.
module tb_pixel_dispatcher;

  localparam int N  = 6;
  localparam int CW = 16;
  localparam int SW = 1280;
  localparam int SH = 720;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] win_x_lo = '0, win_x_hi = '0, win_y_lo = '0, win_y_hi = '0;
  logic [N-1:0]  rdy = '1;
  logic          busy, frame_done, cfg_err;
  logic [31:0]   stall_cycles;

  pixel_dispatcher_if #(.NUM_ENGINES(N), .COORD_W(CW)) pif ();
  assign pif.pix_ready = rdy;

  pixel_dispatcher #(
    .COORD_W(CW), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .NUM_ENGINES(N)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .win_x_lo(win_x_lo), .win_x_hi(win_x_hi), .win_y_lo(win_y_lo), .win_y_hi(win_y_hi),
    .pix_if(pif.master),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 issuing, 2 draining.
  int     m_phase;
  bit     m_v[N];
  int     m_x[N], m_y[N];
  int     m_xlo, m_xhi, m_yhi, m_cx, m_cy;
  bit     m_busy, m_done, m_err;
  longint m_stall;
  int     xfers, dup_cnt;
  bit     seen[int];
  int     vectors = 0, miscompares = 0;

  typedef struct {
    int xlo; int xhi; int ylo; int yhi; int mode; bit exp_err; int exp_pix;
  } vec_t;
  vec_t tbl[8];

  function automatic bit legal(int xlo, int xhi, int ylo, int yhi);
    return (xlo <= xhi) && (xhi < SW) && (ylo <= yhi) && (yhi < SH) && (xhi - xlo + 1 >= N);
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef PIXEL_DISPATCHER_STALL_CNT_EN
    return (m_stall > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stall[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_busy = 0; m_done = 0; m_err = 0; m_stall = 0;
    m_cx = 0; m_cy = 0;
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    seen.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit any_free, empty;
    int nx;
    m_done = 0; m_err = 0;
    empty = 1;
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) empty = 0;
      if (m_v[i] && rdy[i]) begin
        xfers++;
        if (seen.exists(m_y[i] * 65536 + m_x[i])) dup_cnt++;
        seen[m_y[i] * 65536 + m_x[i]] = 1;
      end
    end
    case (m_phase)
      0: if (start && !abort) begin
        if (legal(int'(win_x_lo), int'(win_x_hi), int'(win_y_lo), int'(win_y_hi))) begin
          m_xlo = int'(win_x_lo); m_xhi = int'(win_x_hi); m_yhi = int'(win_y_hi);
          m_cx = m_xlo; m_cy = int'(win_y_lo);
          m_phase = 1; m_busy = 1; m_stall = 0; seen.delete();
        end else begin
          m_err = 1;
        end
      end
      1: begin
        any_free = 0;
        for (int i = 0; i < N; i++) if (!m_v[i] || rdy[i]) any_free = 1;
        if (!any_free) m_stall++;
        if (abort) begin
          for (int i = 0; i < N; i++) m_v[i] = 0;
          m_phase = 0; m_busy = 0;
        end else begin
          nx = m_cx;
          for (int i = 0; i < N; i++) begin
            if (!m_v[i] || rdy[i]) begin
              if (nx <= m_xhi) begin
                m_v[i] = 1; m_x[i] = nx; m_y[i] = m_cy; nx++;
              end else begin
                m_v[i] = 0;
              end
            end
          end
          if (nx > m_xhi) begin
            if (m_cy == m_yhi) m_phase = 2;
            else begin m_cx = m_xlo; m_cy++; end
          end else begin
            m_cx = nx;
          end
        end
      end
      default: begin
        if (abort) begin
          for (int i = 0; i < N; i++) m_v[i] = 0;
          m_phase = 0; m_busy = 0;
        end else if (empty) begin
          m_phase = 0; m_busy = 0; m_done = 1;
        end else begin
          for (int i = 0; i < N; i++) if (rdy[i]) m_v[i] = 0;
        end
      end
    endcase
  endtask

  task automatic check(string tag);
    logic [N-1:0] ev;
    logic [31:0]  es;
    int           bad;
    bit           ok;
    bad = -1;
    for (int i = 0; i < N; i++) begin
      ev[i] = m_v[i];
      if (bad < 0 && (pif.pix_x[i] !== CW'(m_x[i]) || pif.pix_y[i] !== CW'(m_y[i]))) bad = i;
    end
    es = exp_stall();
    ok = (pif.pix_valid === ev) && (busy === m_busy) && (frame_done === m_done) &&
         (cfg_err === m_err) && (stall_cycles === es) && (bad < 0);
    vectors++;
    if (!ok) begin
      miscompares++;
      if (bad < 0) bad = 0;
      $display("FAIL %s t=%0t valid=%b exp %b busy=%b exp %b done=%b exp %b err=%b exp %b stall=%0d exp %0d slot%0d xy=%0d,%0d exp %0d,%0d",
               tag, $time, pif.pix_valid, ev, busy, m_busy, frame_done, m_done, cfg_err, m_err,
               stall_cycles, es, bad, pif.pix_x[bad], pif.pix_y[bad], m_x[bad], m_y[bad]);
    end
  endtask

  task automatic expect_eq(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic start_frame(int xlo, int xhi, int ylo, int yhi);
    win_x_lo = CW'(xlo); win_x_hi = CW'(xhi); win_y_lo = CW'(ylo); win_y_hi = CW'(yhi);
    xfers = 0; dup_cnt = 0;
    start = 1'b1;
    cycle("start");
    start = 1'b0;
  endtask

  task automatic finish_frame(int mode, output int done_seen);
    int n;
    n = 0; done_seen = 0;
    while (m_phase != 0 && n < 400) begin
      case (mode)
        0: rdy = '1;
        1: begin rdy = N'($urandom); start = ($urandom_range(0, 15) == 0); end
        2: begin rdy = '1; if (n < 10) rdy[3] = 1'b0; end
        default: rdy = (n < 4) ? '0 : N'($urandom);
      endcase
      cycle("run");
      if (frame_done === 1'b1) done_seen++;
      if (mode == 2 && n == 5) begin
        expect_eq("slot3_valid_held", longint'(pif.pix_valid[3]), 1);
        expect_eq("slot3_x_held", longint'(pif.pix_x[3]), 3);
      end
      n++;
    end
    start = 1'b0;
    rdy = '1;
    if (m_phase != 0) expect_eq("frame_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen, xlo, xhi, ylo, yhi, w, h, n, exp_pix;

    tbl[0] = '{0, 7, 0, 1, 0, 1'b0, 16};
    tbl[1] = '{0, 7, 0, 1, 2, 1'b0, 16};
    tbl[2] = '{0, 1280, 0, 1, 0, 1'b1, 0};
    tbl[3] = '{10, 13, 0, 0, 0, 1'b1, 0};
    tbl[4] = '{1274, 1279, 717, 719, 1, 1'b0, 18};
    tbl[5] = '{5, 4, 0, 0, 0, 1'b1, 0};
    tbl[6] = '{0, 5, 3, 3, 3, 1'b0, 6};
    tbl[7] = '{0, 0, 0, 0, 0, 1'b1, 0};

    model_reset();
    xfers = 0; dup_cnt = 0;
    repeat (2) @(negedge clk);
    check("reset");
    reset_n = 1'b1;
    cycle("idle");

    // Cycle-exact opening of the 8x2 window.
    start_frame(0, 7, 0, 1);
    cycle("a_load1");
    expect_eq("a_c1_valid", longint'(pif.pix_valid), 6'h3F);
    expect_eq("a_c1_x5", longint'(pif.pix_x[5]), 5);
    expect_eq("a_c1_y0", longint'(pif.pix_y[0]), 0);
    cycle("a_load2");
    expect_eq("a_c2_valid", longint'(pif.pix_valid), 6'h03);
    expect_eq("a_c2_x1", longint'(pif.pix_x[1]), 7);
    finish_frame(0, done_seen);
    expect_eq("a_xfers", xfers, 16);
    expect_eq("a_done", done_seen, 1);

    foreach (tbl[k]) begin
      start_frame(tbl[k].xlo, tbl[k].xhi, tbl[k].ylo, tbl[k].yhi);
      expect_eq("tbl_cfg_err", longint'(cfg_err), longint'(tbl[k].exp_err));
      finish_frame(tbl[k].mode, done_seen);
      expect_eq("tbl_xfers", xfers, tbl[k].exp_pix);
      expect_eq("tbl_done", done_seen, tbl[k].exp_err ? 0 : 1);
      expect_eq("tbl_dup", dup_cnt, 0);
    end

    // start and abort together in IDLE: abort wins.
    win_x_lo = 0; win_x_hi = 7; win_y_lo = 0; win_y_hi = 1;
    start = 1'b1; abort = 1'b1;
    cycle("start_abort");
    start = 1'b0; abort = 1'b0;
    expect_eq("start_abort_busy", longint'(busy), 0);

    // Abort after ten transfers, then restart from the window origin.
    start_frame(2, 9, 1, 4);
    n = 0;
    while (xfers < 10 && n < 50) begin cycle("ab_run"); n++; end
    abort = 1'b1;
    cycle("abort");
    abort = 1'b0;
    expect_eq("abort_valid", longint'(pif.pix_valid), 0);
    expect_eq("abort_busy", longint'(busy), 0);
    expect_eq("abort_done", longint'(frame_done), 0);
    start_frame(2, 9, 1, 4);
    cycle("restart_load");
    expect_eq("restart_x0", longint'(pif.pix_x[0]), 2);
    expect_eq("restart_y0", longint'(pif.pix_y[0]), 1);
    finish_frame(0, done_seen);
    expect_eq("restart_xfers", xfers, 32);
    expect_eq("restart_done", done_seen, 1);

    // start during RUN with another window is ignored.
    start_frame(0, 7, 0, 2);
    cycle("sr_run");
    win_x_lo = 100; win_x_hi = 120; win_y_lo = 5; win_y_hi = 6;
    start = 1'b1;
    cycle("sr_start");
    start = 1'b0;
    finish_frame(0, done_seen);
    expect_eq("sr_xfers", xfers, 24);
    expect_eq("sr_done", done_seen, 1);

    // Asynchronous reset with every slot full and blocked.
    rdy = '0;
    start_frame(0, 7, 0, 1);
    cycle("rs_load");
    expect_eq("rs_full", longint'(pif.pix_valid), 6'h3F);
    repeat (3) cycle("rs_stall");
    #2;
    reset_n = 1'b0;
    #1;
    expect_eq("rs_async_valid", longint'(pif.pix_valid), 0);
    expect_eq("rs_async_busy", longint'(busy), 0);
    expect_eq("rs_async_x5", longint'(pif.pix_x[5]), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rdy = '1;
    check("post_reset");
    expect_eq("rs_stall_zero", longint'(stall_cycles), 0);
    cycle("post_reset_idle");

    // Randomized windows with random ready and stray start pulses.
    for (int r = 0; r < 25; r++) begin
      w = $urandom_range(N - 1, N + 12);
      h = $urandom_range(1, 3);
      xlo = (r % 5 == 0) ? SW - w + int'($urandom_range(0, 1)) : int'($urandom_range(0, 30));
      ylo = (r % 7 == 3) ? SH - 1 : int'($urandom_range(0, SH - 3));
      xhi = xlo + w - 1;
      yhi = (r % 7 == 3) ? SH : ylo + h - 1;
      exp_pix = legal(xlo, xhi, ylo, yhi) ? (xhi - xlo + 1) * (yhi - ylo + 1) : 0;
      start_frame(xlo, xhi, ylo, yhi);
      expect_eq("rnd_cfg_err", longint'(cfg_err), exp_pix == 0 ? 1 : 0);
      finish_frame(1, done_seen);
      expect_eq("rnd_xfers", xfers, exp_pix);
      expect_eq("rnd_done", done_seen, exp_pix == 0 ? 0 : 1);
      expect_eq("rnd_dup", dup_cnt, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
